// File: rtl/mips_pkg.sv
// Shared definitions for the memory unit: state encoding and word geometry.
// Imported by mem_unit and mem_array.
package mips_pkg;

  localparam int WORD_W          = 32;
  localparam int DEPTH_WORDS_DEF = 1024;

  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    LOAD  = 2'b01,
    RUN   = 2'b10
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one asynchronous read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). No reset.
module mem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_unit.sv
// Program/data memory with power-on clear, streaming loader and CPU port.
// Ports: clk, reset (async, active-low); CPU mem_addr/mem_write_en/
// mem_write_data/mem_data; loader ld_valid/ld_data/ld_last/ld_ready;
// status cpu_run, ld_count, fault. Option: MEM_ALIGN_CHK_EN.
module mem_unit
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       mem_addr,
  input  logic              mem_write_en,
  input  logic [31:0]       mem_write_data,
  output logic [31:0]       mem_data,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_run,
  output logic [ADDR_W:0]   ld_count,
  output logic              fault
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH_WORDS - 1);
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(DEPTH_WORDS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
  logic [ADDR_W:0]     ld_count_q, ld_count_d;
  logic                fault_q, fault_d;

  logic                arr_we;
  logic [ADDR_W-1:0]   arr_waddr;
  logic [WORD_W-1:0]   arr_wdata;
  logic [WORD_W-1:0]   arr_rdata;
  logic [ADDR_W-1:0]   cpu_idx;
  logic                in_range;
  logic                misalign;

  assign cpu_idx  = mem_addr[ADDR_W+1:2];
  assign in_range = ~|mem_addr[31:ADDR_W+2];

`ifdef MEM_ALIGN_CHK_EN
  assign misalign = |mem_addr[1:0];
`else
  // Byte-offset bits are don't-care without the alignment check.
  assign misalign = &{1'b0, mem_addr[1:0]};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= CLEAR;
      clr_idx_q  <= '0;
      ld_count_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      ld_count_q <= ld_count_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    ld_count_d = ld_count_q;
    fault_d    = fault_q;
    arr_we     = 1'b0;
    arr_waddr  = clr_idx_q;
    arr_wdata  = '0;
    unique case (state_q)
      CLEAR: begin
        arr_we    = 1'b1;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) state_d = LOAD;
      end
      LOAD: begin
        if (ld_valid) begin
          arr_we     = 1'b1;
          arr_waddr  = ld_count_q[ADDR_W-1:0];
          arr_wdata  = ld_data;
          ld_count_d = ld_count_q + 1'b1;
          // last flag and full array may coincide; one move to RUN
          if (ld_last || ld_count_q == LAST_CNT) state_d = RUN;
        end
      end
      RUN: begin
        arr_waddr = cpu_idx;
        arr_wdata = mem_write_data;
        arr_we    = mem_write_en & in_range & ~misalign;
        if (!in_range || misalign) fault_d = 1'b1;
      end
      default: state_d = CLEAR;
    endcase
  end

  mem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (cpu_idx),
    .rdata (arr_rdata)
  );

  assign ld_ready = (state_q == LOAD);
  assign cpu_run  = (state_q == RUN);
  assign ld_count = ld_count_q;
  assign fault    = fault_q;
  assign mem_data = (cpu_run && in_range) ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit at DEPTH_WORDS=16.
// Reference model tracks mode, load count, fault and a word array.
module tb_mem_unit;

  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   mem_addr = '0;
  logic          mem_write_en = 1'b0;
  logic [31:0]   mem_write_data = '0;
  logic [31:0]   mem_data;
  logic          ld_valid = 1'b0;
  logic [31:0]   ld_data = '0;
  logic          ld_last = 1'b0;
  logic          ld_ready;
  logic          cpu_run;
  logic [AW:0]   ld_count;
  logic          fault;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_unit #(.DEPTH_WORDS(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_addr       (mem_addr),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_data       (mem_data),
    .ld_valid       (ld_valid),
    .ld_data        (ld_data),
    .ld_last        (ld_last),
    .ld_ready       (ld_ready),
    .cpu_run        (cpu_run),
    .ld_count       (ld_count),
    .fault          (fault)
  );

  // model: mode 0 = clearing, 1 = loading, 2 = running
  int          m_mode = 0;
  int          m_clr = 0;
  int          m_cnt = 0;
  bit          m_fault = 1'b0;
  logic [31:0] m_mem [DW];

  function automatic bit bad_align(input logic [31:0] a);
`ifdef MEM_ALIGN_CHK_EN
    return a % 4 != 0;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode  <= 0;
      m_clr   <= 0;
      m_cnt   <= 0;
      m_fault <= 1'b0;
    end else if (m_mode == 0) begin
      m_mem[m_clr] <= 32'h0;
      m_clr        <= m_clr + 1;
      if (m_clr + 1 == DW) m_mode <= 1;
    end else if (m_mode == 1) begin
      if (ld_valid) begin
        m_mem[m_cnt] <= ld_data;
        m_cnt        <= m_cnt + 1;
        if (ld_last || m_cnt + 1 == DW) m_mode <= 2;
      end
    end else begin
      if (mem_addr >= 4 * DW || bad_align(mem_addr))
        m_fault <= 1'b1;
      else if (mem_write_en)
        m_mem[mem_addr / 4] <= mem_write_data;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    if (m_mode != 2 || a >= 4 * DW) return 32'h0;
    return m_mem[a / 4];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ld_ready", 32'(ld_ready), 32'(m_mode == 1));
      chk("cpu_run", 32'(cpu_run), 32'(m_mode == 2));
      chk("ld_count", 32'(ld_count), 32'(m_cnt));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("mem_data", mem_data, exp_rd(mem_addr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (ld_ready !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    chk("ready_wait", 32'(ld_ready), 32'd1);
  endtask

  task automatic ld_word(input logic [31:0] d, input bit last, input bit gap);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    cyc();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = $urandom;
    if (gap) cyc();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input string nm);
    mem_addr = a;
    #1;
    chk(nm, mem_data, exp);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(ld_count), 32'd0);
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_run", 32'(cpu_run), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    int n;
    cyc();
    cyc();
    reset  = 1'b1;
    chk_en = 1'b1;
    wait_ready(n);
    chk("clear_cycles", 32'(n), 32'd16);

    ld_word(32'h2008_0005, 1'b0, 1'b1);
    ld_word(32'h2009_000A, 1'b0, 1'b1);
    ld_word(32'h0000_000D, 1'b1, 1'b0);
    chk("load3_count", 32'(ld_count), 32'd3);
    chk("load3_run", 32'(cpu_run), 32'd1);
    rd(32'h4, 32'h2009_000A, "rd_word1");
    rd(32'h0, 32'h2008_0005, "rd_word0");
    for (int i = 3; i < DW; i++) rd(32'(4 * i), 32'h0, "rd_zero");
    cyc();

    mem_addr       = 32'h3C;
    mem_write_en   = 1'b1;
    mem_write_data = 32'hDEAD_BEEF;
    #1;
    chk("wr_old", mem_data, 32'h0);
    cyc();
    mem_write_en = 1'b0;
    chk("wr_new", mem_data, 32'hDEAD_BEEF);

    mem_addr       = 32'h6;
    mem_write_en   = 1'b1;
    mem_write_data = 32'hCAFE_F00D;
    cyc();
    mem_write_en = 1'b0;
`ifdef MEM_ALIGN_CHK_EN
    rd(32'h4, 32'h2009_000A, "align_word1");
    chk("align_fault", 32'(fault), 32'd1);
`else
    rd(32'h4, 32'hCAFE_F00D, "align_word1");
    chk("align_fault", 32'(fault), 32'd0);
`endif
    cyc();

    mem_addr       = 32'h40;
    mem_write_en   = 1'b1;
    mem_write_data = 32'h1234_5678;
    #1;
    chk("oor_read", mem_data, 32'h0);
    cyc();
    mem_write_en = 1'b0;
    chk("oor_fault", 32'(fault), 32'd1);
    rd(32'h0, 32'h2008_0005, "oor_no_alias");
    repeat (3) cyc();
    chk("fault_held", 32'(fault), 32'd1);
    ld_valid = 1'b1;
    cyc();
    ld_valid = 1'b0;
    chk("count_held", 32'(ld_count), 32'd3);

    pulse_reset();
    wait_ready(n);
    ld_word(32'h1111_1111, 1'b0, 1'b1);
    ld_word(32'h2222_2222, 1'b0, 1'b0);
    chk("mid_count", 32'(ld_count), 32'd2);
    pulse_reset();
    wait_ready(n);
    chk("reclear_cycles", 32'(n), 32'd16);
    ld_word(32'h3333_3333, 1'b1, 1'b0);
    rd(32'h0, 32'h3333_3333, "reload_w0");
    rd(32'h4, 32'h0, "reload_w1");
    rd(32'h8, 32'h0, "reload_w2");
    cyc();

    pulse_reset();
    wait_ready(n);
    for (int i = 0; i < DW; i++)
      ld_word(32'hA000_0000 + 32'(i), i == DW - 1, i % 3 == 0);
    chk("full_count", 32'(ld_count), 32'd16);
    chk("full_run", 32'(cpu_run), 32'd1);
    rd(32'h3C, 32'hA000_000F, "full_last");
    rd(32'h14, 32'hA000_0005, "full_mid");
    repeat (2) cyc();
    chk("full_count_held", 32'(ld_count), 32'd16);

    pulse_reset();
    wait_ready(n);
    for (int i = 0; i < DW; i++)
      ld_word(32'hB000_0000 + 32'(i), 1'b0, 1'b0);
    chk("fill_count", 32'(ld_count), 32'd16);
    chk("fill_run", 32'(cpu_run), 32'd1);
    rd(32'h20, 32'hB000_0008, "fill_w8");
    cyc();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
